// File: rtl/wb_pkg.sv
// Shared types and defaults for the write-back stage and its load queue.
package wb_pkg;

    localparam int WB_DEPTH     = 4;
    localparam int WB_DATA_SIZE = 32;
    localparam int WB_PTR_W     = $clog2(WB_DEPTH);

    // One outstanding load: destination, completion and squash state, returned data.
    typedef struct packed {
        logic                    valid;
        logic [4:0]              rd;
        logic                    done;
        logic                    kill;
        logic [WB_DATA_SIZE-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/ld_queue.sv
// Ordered queue of outstanding load destinations. Entries are pushed at the
// tail on issue, filled strictly in issue order by responses, and popped from
// the head once done. A younger ALU write to the same rd marks older entries
// killed so their data never reaches the register file.
module ld_queue
    import wb_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [4:0]              push_rd,
    input  logic                    resp_valid,
    input  logic [WB_DATA_SIZE-1:0] resp_data,
    input  logic                    pop,
    input  logic                    kill_valid,
    input  logic [4:0]              kill_rd,
    output wb_entry_t               head_entry,
    output logic                    ready,
    output logic [31:0]             pending
);

    localparam int PTR_W = $clog2(DEPTH);

    wb_entry_t          entries [DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [PTR_W:0]     count;
    logic [PTR_W-1:0]   fill;
    logic [PTR_W-1:0]   scan_idx;
    logic               fill_found;
    logic               pop_ok;

    assign head_entry = entries[head];
    assign ready      = (count < (PTR_W+1)'(DEPTH));
    assign pop_ok     = pop && entries[head].valid && entries[head].done;

    // Fill pointer: oldest valid entry still waiting for its data, scanned from head.
    always_comb begin
        fill       = head;
        fill_found = 1'b0;
        scan_idx   = head;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head + PTR_W'(i);
            if (!fill_found && entries[scan_idx].valid && !entries[scan_idx].done) begin
                fill       = scan_idx;
                fill_found = 1'b1;
            end
        end
    end

    // Registers whose value is still owed to the register file by a live load.
    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entries[i].valid && !entries[i].kill) begin
                pending[entries[i].rd] = 1'b1;
            end
        end
    end

    // Entry storage: kill marking, response fill, pop and push. The push is
    // written last so a same-cycle issue to a killed rd keeps its own clean state.
    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill_valid && entries[i].valid && (entries[i].rd == kill_rd)) begin
                    entries[i].kill <= 1'b1;
                end
            end
            if (resp_valid && fill_found) begin
                entries[fill].data <= resp_data;
                entries[fill].done <= 1'b1;
            end
            if (pop_ok) begin
                entries[head].valid <= 1'b0;
                head                <= head + 1'b1;
            end
            if (push) begin
                entries[tail].valid <= 1'b1;
                entries[tail].rd    <= push_rd;
                entries[tail].done  <= 1'b0;
                entries[tail].kill  <= (push_rd == 5'd0);
                entries[tail].data  <= '0;
                tail                <= tail + 1'b1;
            end
        end
    end

    // Occupancy count; a simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            case ({push, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/reg_writeback.sv
// Write-back stage: sole writer of the register-file write port. ALU results
// take priority; completed loads drain in issue order when the ALU is idle.
// Decode is stalled (hazard) while a source register still has a write in flight.
module reg_writeback
    import wb_pkg::*;
#(
    parameter int DEPTH     = WB_DEPTH,
    parameter int DATA_SIZE = WB_DATA_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alu_valid,
    input  logic [4:0]           alu_rd,
    input  logic [DATA_SIZE-1:0] alu_data,
    input  logic                 ld_issue,
    input  logic [4:0]           ld_issue_rd,
    output logic                 ld_ready,
    input  logic                 ld_resp_valid,
    input  logic [DATA_SIZE-1:0] ld_resp_data,
    input  logic [4:0]           q1_addr,
    input  logic [4:0]           q2_addr,
    output logic                 hazard,
    output logic                 write_reg,
    output logic [4:0]           rd_addr,
    output logic [DATA_SIZE-1:0] write_data
);

    wb_entry_t   head_entry;
    logic [31:0] pending;
    logic        alu_write;
    logic        ld_pop;
    logic        ld_push;
    logic        q1_busy;
    logic        q2_busy;

    assign alu_write = alu_valid && (alu_rd != 5'd0);
    assign ld_pop    = !alu_valid && head_entry.valid && head_entry.done;
    assign ld_push   = ld_issue && ld_ready;

    ld_queue #(
        .DEPTH (DEPTH)
    ) u_ld_queue (
        .clk        (clk),
        .rst        (rst),
        .push       (ld_push),
        .push_rd    (ld_issue_rd),
        .resp_valid (ld_resp_valid),
        .resp_data  (WB_DATA_SIZE'(ld_resp_data)),
        .pop        (ld_pop),
        .kill_valid (alu_write),
        .kill_rd    (alu_rd),
        .head_entry (head_entry),
        .ready      (ld_ready),
        .pending    (pending)
    );

    // Commit arbitration into the register-file output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            write_reg  <= 1'b0;
            rd_addr    <= '0;
            write_data <= '0;
        end else if (alu_valid) begin
            write_reg <= alu_write;
            if (alu_write) begin
                rd_addr    <= alu_rd;
                write_data <= alu_data;
            end
        end else if (ld_pop) begin
            // A killed entry drains without touching the register file.
            write_reg <= !head_entry.kill;
            if (!head_entry.kill) begin
                rd_addr    <= head_entry.rd;
                write_data <= DATA_SIZE'(head_entry.data);
            end
        end else begin
            write_reg <= 1'b0;
        end
    end

    // RAW stall: a source is busy while a live load or the in-flight output targets it.
    always_comb begin
        q1_busy = (q1_addr != 5'd0) &&
                  (pending[q1_addr] || (write_reg && (rd_addr == q1_addr)));
        q2_busy = (q2_addr != 5'd0) &&
                  (pending[q2_addr] || (write_reg && (rd_addr == q2_addr)));
        hazard  = q1_busy || q2_busy;
    end

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: expected register-file writes are
// queued when stimulus is driven and matched (cycle, rd, data) as they appear.
module tb_reg_writeback;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_issue;
    logic [4:0]  ld_issue_rd;
    logic        ld_ready;
    logic        ld_resp_valid;
    logic [31:0] ld_resp_data;
    logic [4:0]  q1_addr;
    logic [4:0]  q2_addr;
    logic        hazard;
    logic        write_reg;
    logic [4:0]  rd_addr;
    logic [31:0] write_data;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    reg_writeback #(
        .DEPTH     (4),
        .DATA_SIZE (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .alu_valid     (alu_valid),
        .alu_rd        (alu_rd),
        .alu_data      (alu_data),
        .ld_issue      (ld_issue),
        .ld_issue_rd   (ld_issue_rd),
        .ld_ready      (ld_ready),
        .ld_resp_valid (ld_resp_valid),
        .ld_resp_data  (ld_resp_data),
        .q1_addr       (q1_addr),
        .q2_addr       (q2_addr),
        .hazard        (hazard),
        .write_reg     (write_reg),
        .rd_addr       (rd_addr),
        .write_data    (write_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expect_write(input logic [4:0] rd, input logic [31:0] d, input int c);
        exp_t e;
        e.rd   = rd;
        e.data = d;
        e.cyc  = c;
        sb.push_back(e);
    endtask

    task automatic idle_inputs();
        alu_valid     = 1'b0;
        ld_issue      = 1'b0;
        ld_resp_valid = 1'b0;
    endtask

    // Monitor: every write seen on the port must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (write_reg === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_write", {63'd0, write_reg}, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("wb_cycle", 64'(cyc), 64'(e.cyc));
                    check("wb_rd", {59'd0, rd_addr}, {59'd0, e.rd});
                    check("wb_data", {32'd0, write_data}, {32'd0, e.data});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0]  r;
        logic [31:0] d;

        rst           = 1'b1;
        alu_valid     = 1'b1;
        alu_rd        = 5'd5;
        alu_data      = 32'h5555;
        ld_issue      = 1'b0;
        ld_issue_rd   = 5'd0;
        ld_resp_valid = 1'b0;
        ld_resp_data  = 32'd0;
        q1_addr       = 5'd0;
        q2_addr       = 5'd0;
        @(negedge clk);

        // Reset held two cycles with ALU traffic present.
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_write_reg", {63'd0, write_reg}, 64'd0);
            check("rst_rd_addr", {59'd0, rd_addr}, 64'd0);
            check("rst_write_data", {32'd0, write_data}, 64'd0);
            check("rst_ld_ready", {63'd0, ld_ready}, 64'd1);
        end
        rst = 1'b0;
        idle_inputs();
        q1_addr = 5'd5;
        #1;
        check("rst_hazard", {63'd0, hazard}, 64'd0);

        // ALU commit, then rd=0 produces no write.
        alu_valid = 1'b1;
        alu_rd    = 5'd5;
        alu_data  = 32'h1234;
        expect_write(5'd5, 32'h1234, cyc + 1);
        tick();
        #1;
        check("alu_hazard_inflight", {63'd0, hazard}, 64'd1);
        alu_rd   = 5'd0;
        alu_data = 32'hFFFF;
        tick();
        check("alu_rd0_no_write", {63'd0, write_reg}, 64'd0);
        alu_valid = 1'b0;
        #1;
        check("alu_hazard_clear", {63'd0, hazard}, 64'd0);

        // Back-to-back ALU results.
        for (int i = 0; i < 6; i++) begin
            r = 5'($urandom_range(1, 31));
            d = $urandom;
            alu_valid = 1'b1;
            alu_rd    = r;
            alu_data  = d;
            expect_write(r, d, cyc + 1);
            tick();
        end
        idle_inputs();
        tick();

        // Load to r7 with hazard; response three cycles after issue.
        q1_addr     = 5'd7;
        ld_issue    = 1'b1;
        ld_issue_rd = 5'd7;
        tick();
        ld_issue = 1'b0;
        #1;
        check("ld_hazard_issued", {63'd0, hazard}, 64'd1);
        tick();
        tick();
        ld_resp_valid = 1'b1;
        ld_resp_data  = 32'hCAFE;
        expect_write(5'd7, 32'hCAFE, cyc + 2);
        tick();
        ld_resp_valid = 1'b0;
        #1;
        check("ld_hazard_done", {63'd0, hazard}, 64'd1);
        tick();
        check("ld_write_reg", {63'd0, write_reg}, 64'd1);
        check("ld_hazard_commit", {63'd0, hazard}, 64'd1);
        tick();
        check("ld_hazard_fall", {63'd0, hazard}, 64'd0);

        // Collision: load r3 completes while ALU writes r4 for two cycles.
        q1_addr     = 5'd0;
        ld_issue    = 1'b1;
        ld_issue_rd = 5'd3;
        tick();
        ld_issue = 1'b0;
        tick();
        ld_resp_valid = 1'b1;
        ld_resp_data  = 32'h3333;
        alu_valid     = 1'b1;
        alu_rd        = 5'd4;
        alu_data      = 32'hA1;
        expect_write(5'd4, 32'hA1, cyc + 1);
        expect_write(5'd4, 32'hA2, cyc + 2);
        expect_write(5'd3, 32'h3333, cyc + 3);
        tick();
        ld_resp_valid = 1'b0;
        alu_data      = 32'hA2;
        q2_addr       = 5'd3;
        #1;
        check("coll_hazard_q2", {63'd0, hazard}, 64'd1);
        tick();
        idle_inputs();
        q2_addr = 5'd0;
        tick();
        tick();

        // WAW: younger ALU write to r9 squashes the outstanding load.
        ld_issue    = 1'b1;
        ld_issue_rd = 5'd9;
        tick();
        ld_issue  = 1'b0;
        alu_valid = 1'b1;
        alu_rd    = 5'd9;
        alu_data  = 32'h11;
        expect_write(5'd9, 32'h11, cyc + 1);
        tick();
        alu_valid = 1'b0;
        q1_addr   = 5'd9;
        #1;
        check("waw_hazard_alu", {63'd0, hazard}, 64'd1);
        tick();
        check("waw_hazard_drop", {63'd0, hazard}, 64'd0);
        ld_resp_valid = 1'b1;
        ld_resp_data  = 32'hDEAD;
        tick();
        ld_resp_valid = 1'b0;
        tick();
        tick();
        check("waw_ld_ready", {63'd0, ld_ready}, 64'd1);
        q1_addr = 5'd0;

        // Fill the queue.
        for (int i = 1; i <= 4; i++) begin
            ld_issue    = 1'b1;
            ld_issue_rd = 5'(i);
            tick();
        end
        ld_issue = 1'b0;
        check("full_ld_ready", {63'd0, ld_ready}, 64'd0);
        q1_addr = 5'd3;
        #1;
        check("full_hazard", {63'd0, hazard}, 64'd1);
        for (int i = 0; i < 4; i++) begin
            ld_resp_valid = 1'b1;
            ld_resp_data  = 32'h100 + 32'(i);
            expect_write(5'(i + 1), 32'h100 + 32'(i), cyc + 2);
            tick();
            if (i == 0) check("full_ready_before_pop", {63'd0, ld_ready}, 64'd0);
            if (i == 1) check("full_ready_after_pop", {63'd0, ld_ready}, 64'd1);
        end
        ld_resp_valid = 1'b0;

        // Second pass wraps the pointers, with issue and response overlapping.
        for (int i = 0; i <= 4; i++) begin
            ld_issue    = (i < 4);
            ld_issue_rd = 5'(11 + i);
            if (i > 0) begin
                ld_resp_valid = 1'b1;
                ld_resp_data  = 32'h200 + 32'(i - 1);
                expect_write(5'(10 + i), 32'h200 + 32'(i - 1), cyc + 2);
            end
            tick();
        end
        idle_inputs();
        tick();
        tick();
        q1_addr = 5'd14;
        #1;
        check("wrap_hazard_clear", {63'd0, hazard}, 64'd0);
        check("wrap_ld_ready", {63'd0, ld_ready}, 64'd1);

        // Reset mid-operation discards outstanding loads; late data is ignored.
        q1_addr = 5'd20;
        for (int i = 0; i < 2; i++) begin
            ld_issue    = 1'b1;
            ld_issue_rd = 5'(20 + i);
            tick();
        end
        ld_issue = 1'b0;
        #1;
        check("midrst_hazard_before", {63'd0, hazard}, 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("midrst_hazard_after", {63'd0, hazard}, 64'd0);
        check("midrst_ld_ready", {63'd0, ld_ready}, 64'd1);
        check("midrst_write_reg", {63'd0, write_reg}, 64'd0);
        ld_resp_valid = 1'b1;
        ld_resp_data  = 32'hBAD;
        tick();
        ld_resp_valid = 1'b0;
        tick();
        tick();

        // Queue still usable after reset.
        ld_issue    = 1'b1;
        ld_issue_rd = 5'd22;
        tick();
        ld_issue      = 1'b0;
        ld_resp_valid = 1'b1;
        ld_resp_data  = 32'h2222;
        expect_write(5'd22, 32'h2222, cyc + 2);
        tick();
        idle_inputs();
        for (int i = 0; i < 5; i++) tick();

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_writeback.md
# reg_writeback

Write-back stage of the RV32 core; the single writer of the `register` block's write port (`write_reg`/`rd_addr`/`write_data`). It merges single-cycle ALU results with in-order, variable-latency load responses and tracks outstanding load destinations in a small ordered queue. It raises a RAW hazard for decode while a queried source register has a write not yet committed to the register file. It also squashes stale load writes when a younger ALU result targets the same register (WAW).

## Interface
- DEPTH, 4, maximum outstanding loads (power of 2, ≥2)
- DATA_SIZE, 32, data width

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- alu_valid  in  1  ALU result present this cycle
- alu_rd  in  5  ALU destination
- alu_data  in  DATA_SIZE  ALU result
- ld_issue  in  1  load issued this cycle (legal only when ld_ready=1)
- ld_issue_rd  in  5  load destination
- ld_ready  out  1  queue count < DEPTH (combinational from state)
- ld_resp_valid  in  1  load data returned, strictly in issue order
- ld_resp_data  in  DATA_SIZE  load data
- q1_addr, q2_addr  in  5 each  decode source registers
- hazard  out  1  combinational RAW stall request
- write_reg  out  1  register-file write enable (registered)
- rd_addr  out  5  register-file write address (registered)
- write_data  out  DATA_SIZE  register-file write data (registered)

## Operation
- Queue entries hold {valid, rd, done, kill, data}. Head = oldest entry; fill pointer = oldest valid entry with done=0.
- ld_issue pushes {rd, done=0, kill=(rd==0)} at the tail.
- ld_resp_valid writes data to the fill-pointer entry and sets done=1. A response with no undone entry is ignored.
- Commit arbitration each cycle:
  - alu_valid has priority. If alu_rd≠0, the output registers load {1, alu_rd, alu_data}. If alu_rd=0, write_reg=0.
  - Otherwise, a head entry with done=1 pops. It drives write_reg=!kill with its rd and data. A killed entry pops silently.
- WAW squash: alu_valid with alu_rd≠0 sets kill=1 on every valid queue entry with rd==alu_rd. A same-cycle ld_issue to that rd is younger and is not killed.
- Pending registers are all valid, non-killed entries, plus the output register when write_reg=1.
- hazard = (q1≠0 and q1 pending) or (q2≠0 and q2 pending).
- Simultaneous push and pop are allowed; count is unchanged.
- No output writes x0.

## Timing
- Reset values: write_reg=0, rd_addr=0, write_data=0, queue empty, ld_ready=1, hazard=0.
- ALU result sampled in cycle N → write_reg=1 in cycle N+1. The register file commits it at the end of N+1.
- Load response sampled in cycle N → entry done in N+1. It pops in N+1 if alu_valid=0, else in the first later cycle with alu_valid=0. write_reg=1 the cycle after the pop.
- Minimum issue-to-response latency is 1 cycle. A response can never match a same-cycle issue.
- hazard clears in the cycle after the write_reg=1 cycle for that rd.
- ld_ready=0 at count=DEPTH. A pop in that cycle does not raise it until the next cycle.
- Pointers wrap modulo DEPTH.
- rst mid-operation clears all entries and outputs in the next cycle. Late responses after reset are ignored.

## Structure
- Package wb_pkg:
  - DEPTH and DATA_SIZE defaults
  - wb_entry_t struct {valid, rd, done, kill, data}
  - pointer width constant $clog2(DEPTH)
- Sub-module ld_queue: entry storage, head/tail/fill pointers, count, kill-match logic and the pending bitmap output.
- reg_writeback owns arbitration, the output registers and hazard.

## Test plan
- Reset: rst=1 for 2 cycles with alu_valid=1 → write_reg=0, rd_addr=0, write_data=0, ld_ready=1 throughout.
- ALU only: alu_valid=1, rd=5, data=0x1234 in cycle N → cycle N+1 write_reg=1, rd_addr=5, write_data=0x1234. Same stimulus with rd=0 → write_reg=0.
- Load and hazard: issue rd=7, q1=7 → hazard=1.
  - Response 0xCAFE arrives 3 cycles later → write_reg=1, rd_addr=7, write_data=0xCAFE two cycles after the response.
  - hazard falls the following cycle.
- Collision: load rd=3 done while alu_valid=1, rd=4 for 2 cycles → ALU writes first, then the load rd=3 commits in the cycle after ALU traffic stops.
- WAW: issue load rd=9, then ALU rd=9 data=0x11 before the response → only 0x11 is written. The load pops silently, and hazard on q1=9 drops after the ALU commit.
- Full and wrap: issue 4 loads (rd 1–4) → ld_ready=0. Respond to all, then issue 4 more → writes occur in issue order with no loss across the pointer wrap. An rst pulse mid-sequence empties the queue.
